// File: rtl/uart_fifo_v2_if.sv
// uart_fifo_v2_if - write/read handshake bundle for uart_fifo_v2.
//   master : the side driving requests (wr_en, wr_data, rd_en);
//            it sees full, rd_data, rd_valid and empty.
//   slave  : the FIFO itself, which drives full, rd_data, rd_valid and empty.
interface uart_fifo_v2_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             empty;

    modport master (
        output wr_en, wr_data, rd_en,
        input  full, rd_data, rd_valid, empty
    );

    modport slave (
        input  wr_en, wr_data, rd_en,
        output full, rd_data, rd_valid, empty
    );
endinterface

// File: rtl/uart_fifo_v2.sv
// uart_fifo_v2 - parametrised synchronous FIFO between the UART byte engines
// and the host side. Register-array storage, registered-read or
// first-word-fall-through read port, almost-full/almost-empty flags, sticky
// overflow/underflow flags and a synchronous flush.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           clears pointers/count/rd_valid (error flags untouched)
//   clr_err         clears sticky overflow/underflow
//   bus (slave)     wr_en/wr_data/full, rd_en/rd_data/rd_valid/empty
//   almost_full     count >= AF_THRESH
//   almost_empty    count <= AE_THRESH
//   overflow        sticky: write attempted while full
//   underflow       sticky: read attempted while empty
//   count           stored words, 0..DEPTH
//   max_count       (only with UART_FIFO_WATERMARK_EN) high-water mark of count
//
// Optional feature macro: UART_FIFO_WATERMARK_EN adds the max_count port.
module uart_fifo_v2 #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       clr_err,
    uart_fifo_v2_if.slave              bus,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       almost_empty,
    output logic                       underflow,
    output logic [$clog2(DEPTH):0]     count
`ifdef UART_FIFO_WATERMARK_EN
    ,
    output logic [$clog2(DEPTH):0]     max_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full_s;
    logic             empty_s;
    logic             wr_acc;
    logic             rd_acc;

    assign full_s       = (count == DEPTH_C);
    assign empty_s      = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign bus.full     = full_s;
    assign bus.empty    = empty_s;

    // A read in the same cycle never frees room for a write, and a write
    // never makes an empty FIFO readable: both accepts look only at the
    // registered count.
    assign wr_acc = bus.wr_en & ~full_s;
    assign rd_acc = bus.rd_en & ~empty_s;

    // Storage is never cleared; flush only moves the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset && !flush) begin
            mem[wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // A new error event in the same cycle as clr_err wins.
            overflow  <= (bus.wr_en & full_s)  | (overflow  & ~clr_err);
            underflow <= (bus.rd_en & empty_s) | (underflow & ~clr_err);
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] rd_data_q;
            logic             rd_valid_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else if (flush) begin
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_valid_q <= rd_acc;
                    if (rd_acc) begin
                        rd_data_q <= mem[rd_ptr];
                    end
                end
            end

            assign bus.rd_data  = rd_data_q;
            assign bus.rd_valid = rd_valid_q;
        end else begin : g_fwft_read
            // Head word shown directly; zero while empty so the output is
            // defined out of reset before any word has been written.
            assign bus.rd_data  = empty_s ? '0 : mem[rd_ptr];
            assign bus.rd_valid = ~empty_s;
        end
    endgenerate

`ifdef UART_FIFO_WATERMARK_EN
    // Tracks the registered count, so it trails count by one cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            max_count <= '0;
        end else if (clr_err) begin
            max_count <= count;
        end else if (count > max_count) begin
            max_count <= count;
        end
    end
`endif

endmodule

// File: tb/tb_uart_fifo_v2.sv
module tb_uart_fifo_v2;

    logic clk;
    logic reset;
    logic flush;
    logic clr_err;

    logic       af_a, ovf_a, ae_a, unf_a;
    logic       af_b, ovf_b, ae_b, unf_b;
    logic [4:0] cnt_a, cnt_b;
`ifdef UART_FIFO_WATERMARK_EN
    logic [4:0] mc_a, mc_b;
`endif

    uart_fifo_v2_if #(.WIDTH(8)) ifa ();
    uart_fifo_v2_if #(.WIDTH(8)) ifb ();

    uart_fifo_v2 #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AF_THRESH(14), .AE_THRESH(2)) dut_reg (
        .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err), .bus(ifa),
        .almost_full(af_a), .overflow(ovf_a), .almost_empty(ae_a), .underflow(unf_a),
        .count(cnt_a)
`ifdef UART_FIFO_WATERMARK_EN
        , .max_count(mc_a)
`endif
    );

    uart_fifo_v2 #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_THRESH(14), .AE_THRESH(2)) dut_fwft (
        .clk(clk), .reset(reset), .flush(flush), .clr_err(clr_err), .bus(ifb),
        .almost_full(af_b), .overflow(ovf_b), .almost_empty(ae_b), .underflow(unf_b),
        .count(cnt_b)
`ifdef UART_FIFO_WATERMARK_EN
        , .max_count(mc_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of stored words plus flag state.
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    logic       m_rv0 = 1'b0;
    logic [7:0] m_rd0 = 8'h00;
    int         m_max = 0;

    initial forever begin
        @(posedge clk);
        if (reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            m_rv0 = 1'b0;
            m_rd0 = 8'h00;
            m_max = 0;
        end else if (flush) begin
            q.delete();
            m_rv0 = 1'b0;
            m_max = 0;
        end else begin
            int  n;
            bit  is_full, is_empty;
            n        = q.size();
            is_full  = (n == 16);
            is_empty = (n == 0);
            if (clr_err) m_max = n;
            else if (n > m_max) m_max = n;
            m_ovf = (ifa.wr_en && is_full)  || (m_ovf && !clr_err);
            m_unf = (ifa.rd_en && is_empty) || (m_unf && !clr_err);
            m_rv0 = ifa.rd_en && !is_empty;
            if (m_rv0) m_rd0 = q.pop_front();
            if (ifa.wr_en && !is_full) q.push_back(ifa.wr_data);
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("count_a",   cnt_a, q.size());
            chk("count_b",   cnt_b, q.size());
            chk("full",      ifa.full, q.size() == 16);
            chk("empty",     ifa.empty, q.size() == 0);
            chk("almost_full",  af_a, q.size() >= 14);
            chk("almost_empty", ae_a, q.size() <= 2);
            chk("overflow",  ovf_a, m_ovf);
            chk("underflow", unf_a, m_unf);
            chk("ovf_b",     ovf_b, m_ovf);
            chk("unf_b",     unf_b, m_unf);
            chk("reg_rd_valid", ifa.rd_valid, m_rv0);
            chk("reg_rd_data",  ifa.rd_data, m_rd0);
            chk("fwft_rd_valid", ifb.rd_valid, q.size() != 0);
            if (q.size() != 0) chk("fwft_rd_data", ifb.rd_data, q[0]);
`ifdef UART_FIFO_WATERMARK_EN
            chk("max_count_a", mc_a, m_max);
            chk("max_count_b", mc_b, m_max);
`endif
        end
    end

    // Drive one cycle of stimulus to both FIFOs, then return to idle
    // 1 time unit after the edge.
    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic f = 1'b0, input logic c = 1'b0, input logic rs = 1'b0);
        ifa.wr_en = w;  ifa.wr_data = d;  ifa.rd_en = r;
        ifb.wr_en = w;  ifb.wr_data = d;  ifb.rd_en = r;
        flush = f;  clr_err = c;  reset = rs;
        @(posedge clk);
        #1;
        ifa.wr_en = 1'b0;  ifa.rd_en = 1'b0;
        ifb.wr_en = 1'b0;  ifb.rd_en = 1'b0;
        flush = 1'b0;  clr_err = 1'b0;  reset = 1'b0;
    endtask

    initial begin
        ifa.wr_en = 1'b0; ifa.wr_data = 8'h00; ifa.rd_en = 1'b0;
        ifb.wr_en = 1'b0; ifb.wr_data = 8'h00; ifb.rd_en = 1'b0;
        flush = 1'b0; clr_err = 1'b0; reset = 1'b1;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(0, 8'h00, 0, 0, 0, 1);

        // Reset state
        chk("rst_count", cnt_a, 0);
        chk("rst_empty", ifa.empty, 1);
        chk("rst_ae", ae_a, 1);
        chk("rst_af", af_a, 0);
        chk("rst_full", ifa.full, 0);
        chk("rst_rd_data", ifa.rd_data, 8'h00);
        chk("rst_rd_valid", ifa.rd_valid, 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        chk("fill_full", ifa.full, 1);
        chk("fill_count", cnt_a, 16);
        chk("fill_model_size", q.size(), 16);

        // Write to full is dropped and sets overflow
        step(1, 8'hAA, 0);
        chk("ovf_set", ovf_a, 1);
        chk("ovf_count", cnt_a, 16);

        // Registered reads: data 0x00..0x0F one cycle after each rd_en
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1);
            chk("rd_seq_valid", ifa.rd_valid, 1);
            chk("rd_seq_data", ifa.rd_data, 8'(i));
        end
        step(0, 8'h00, 0);
        chk("rd_pulse_end", ifa.rd_valid, 0);
        chk("drain_empty", ifa.empty, 1);

        // Read from empty sets underflow; overflow still held
        step(0, 8'h00, 1);
        chk("unf_set", unf_a, 1);
        chk("ovf_sticky", ovf_a, 1);
        step(0, 8'h00, 0, 0, 1);
        chk("clr_ovf", ovf_a, 0);
        chk("clr_unf", unf_a, 0);

        // FWFT: word visible the cycle after the write, without rd_en
        step(1, 8'h5A, 0);
        chk("fwft_valid", ifb.rd_valid, 1);
        chk("fwft_data", ifb.rd_data, 8'h5A);
        step(0, 8'h00, 1);
        chk("fwft_pop_empty", ifb.empty, 1);
        chk("fwft_pop_valid", ifb.rd_valid, 0);

        // Count 8, then 20 cycles of simultaneous write+read across the wrap
        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 8'(8'h18 + i), 1);
            chk("simul_data", ifa.rd_data, 8'(8'h10 + i));
        end
        chk("simul_count", cnt_a, 8);
        for (int i = 0; i < 8; i++) step(0, 8'h00, 1);

        // Threshold sweep over counts 1..16
        for (int k = 1; k <= 16; k++) begin
            step(1, 8'(k), 0);
            chk("sweep_ae", ae_a, k <= 2);
            chk("sweep_af", af_a, k >= 14);
        end
        step(1, 8'hBB, 0);
        step(0, 8'h00, 0, 0, 1);

        // Flush at count 10; write in the flush cycle is discarded
        for (int i = 0; i < 6; i++) step(0, 8'h00, 1);
        chk("pre_flush_count", cnt_a, 10);
        step(1, 8'hEE, 1, 1);
        chk("flush_count", cnt_a, 0);
        chk("flush_empty", ifa.empty, 1);
        chk("flush_no_unf", unf_a, 0);
        chk("flush_rv", ifa.rd_valid, 0);
        step(1, 8'h33, 0);
        chk("post_flush_data", ifb.rd_data, 8'h33);
        chk("post_flush_count", cnt_a, 1);
        step(0, 8'h00, 1);

        // Watermark: write 12, read 12, write 3
        for (int i = 0; i < 12; i++) step(1, 8'(8'h40 + i), 0);
        for (int i = 0; i < 12; i++) step(0, 8'h00, 1);
        for (int i = 0; i < 3; i++) step(1, 8'(8'h60 + i), 0);
        step(0, 8'h00, 0);
`ifdef UART_FIFO_WATERMARK_EN
        chk("wm_peak", mc_a, 12);
`endif
        step(0, 8'h00, 0, 0, 1);
`ifdef UART_FIFO_WATERMARK_EN
        chk("wm_clr", mc_a, 3);
`endif

        // Reset together with a read cancels the would-be rd_valid pulse
        step(0, 8'h00, 1, 0, 0, 1);
        chk("midrst_rv", ifa.rd_valid, 0);
        chk("midrst_count", cnt_a, 0);
        chk("midrst_rd_data", ifa.rd_data, 8'h00);

        step(0, 8'h00, 0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_fifo_v2.md
Name: uart_fifo_v2

Overview:
- Parametrised synchronous FIFO, successor to the UART TX/RX buffer FIFO.
- Adds first-word-fall-through (FWFT) or registered-read mode, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and a synchronous flush.
- Storage is an internal register array; there is no external RAM instance.
- Sits between the UART byte engines and the host/bus side.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; must be a power of two, >=2.
- FWFT, 0, 0 = registered-read mode; 1 = first-word-fall-through mode.
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous clear of contents; error flags are unaffected.
- clr_err  in  1  clears the sticky overflow/underflow flags.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- full  out  1  count == DEPTH.
- almost_full  out  1  count >= AF_THRESH.
- overflow  out  1  sticky: a write was attempted while full.
- rd_en  in  1  read request (pop).
- rd_data  out  WIDTH  read data.
- rd_valid  out  1  rd_data qualifier (meaning depends on mode).
- empty  out  1  count == 0.
- almost_empty  out  1  count <= AE_THRESH.
- underflow  out  1  sticky: a read was attempted while empty.
- count  out  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.

Behaviour:
- Reset values: count, pointers, overflow, underflow and rd_valid = 0; rd_data = 0; empty = 1; almost_empty = 1; full = 0; almost_full = (AF_THRESH == 0).
- Priority, highest first: reset, flush, clr_err/error set, normal operation.
- Accept rules:
  - Write accepted iff wr_en & ~full. There is no write-through-when-full, even if a read occurs in the same cycle.
  - Read accepted iff rd_en & ~empty. A write in the same cycle does not make an empty FIFO readable.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - Each increments by 1 per accepted operation.
- Count:
  - +1 on write-only, -1 on read-only.
  - Unchanged on simultaneous accepted read and write, or when neither is accepted.
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count.
- Errors:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both hold until clr_err or reset.
  - If a set and clr_err occur in the same cycle, set wins.
- Registered-read mode (FWFT=0):
  - An accepted read loads mem[rd_ptr] into rd_data at the clock edge.
  - rd_valid pulses high for exactly 1 cycle, in the cycle after acceptance (latency 1).
  - rd_data holds its value when no read is accepted.
  - Back-to-back reads give one word per cycle.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] continuously; rd_valid = ~empty.
  - rd_en acts as an acknowledge/pop; the next word is visible in the following cycle.
  - Write-to-visible latency is 1 cycle: the word is visible in the cycle after the write into an empty FIFO.
- Flush:
  - Pointers, count and rd_valid go to 0 in the next cycle.
  - Reads and writes in the flush cycle are ignored; in particular, overflow and underflow are not set.
  - Memory contents are not cleared.
- Reset mid-operation: everything returns to reset values in the next cycle, and any pending rd_valid is cancelled.

Optional Feature:
- Macro: UART_FIFO_WATERMARK_EN.
- Defined:
  - Adds output port max_count, width $clog2(DEPTH)+1.
  - max_count records the highest count value reached since reset/clr_err and updates one cycle after count changes.
  - clr_err loads it with the current count; reset/flush load 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- DEPTH=16, FWFT=0: write 0x00..0x0F, then read 16 -> full=1 after 16th write; rd_data 0x00..0x0F in order, each with a 1-cycle rd_valid pulse 1 cycle after rd_en; empty=1 at end.
- Full FIFO + wr_en of 0xAA -> write dropped, overflow=1 sticky, count stays 16; read from empty -> underflow=1; clr_err -> both 0.
- FWFT=1: write 0x5A into empty -> next cycle rd_valid=1, rd_data=0x5A without rd_en; pop -> empty=1, rd_valid=0.
- Count at 8, simultaneous wr_en and rd_en for 20 cycles -> count stays 8; pointers wrap past 15; read data remains in order.
- AF_THRESH=14, AE_THRESH=2:
  - Fill 0..16 -> almost_empty=1 for count<=2; almost_full=1 from count 14.
  - Flush at count 10 -> count=0, empty=1 next cycle; a write in the flush cycle is not stored.
- With UART_FIFO_WATERMARK_EN: write 12, read 12, write 3 -> max_count=12; clr_err -> max_count=3.
